// File: rtl/des_key_sched_dec_if.sv
// des_key_sched_dec_if: key-in / subkey-out handshake bundle for des_key_sched_dec.
// Carries the enc select only when DES_KS_ENC_MODE_EN is defined.
interface des_key_sched_dec_if;
   logic [1:64] key_in;
   logic        key_valid;
   logic        key_ready;
   logic [1:48] subkey;
   logic [3:0]  subkey_round;
   logic        subkey_valid;
   logic        subkey_ready;
   logic        busy;
`ifdef DES_KS_ENC_MODE_EN
   logic        enc;
`endif
   modport master (
`ifdef DES_KS_ENC_MODE_EN
      output enc,
`endif
      output key_in, key_valid, subkey_ready,
      input  key_ready, subkey, subkey_round, subkey_valid, busy
   );
   modport slave (
`ifdef DES_KS_ENC_MODE_EN
      input  enc,
`endif
      input  key_in, key_valid, subkey_ready,
      output key_ready, subkey, subkey_round, subkey_valid, busy
   );
endinterface

// File: rtl/des_key_sched_dec.sv
// des_key_sched_dec: DES subkeys K16..K1 from a rotating C/D register, one per handshake.
// DES_KS_ENC_MODE_EN adds an enc input selecting K1..K16 order.
module des_key_sched_dec (
   input logic clk,
   input logic rst,
   des_key_sched_dec_if.slave bus
);
   typedef enum logic {IDLE, RUN} state_t;
   localparam int PC1 [0:55] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
   localparam int PC2 [0:47] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
   function automatic logic [1:56] pc1(input logic [1:64] k);
      logic [1:56] r;
      for (int i = 0; i < 56; i++) r[i+1] = k[PC1[i]];
      return r;
   endfunction
   function automatic logic [1:48] pc2(input logic [1:56] cd);
      logic [1:48] r;
      for (int i = 0; i < 48; i++) r[i+1] = cd[PC2[i]];
      return r;
   endfunction
   // Rounds 1, 2, 9 and 16 (index 0, 1, 8, 15) shift by one, all others by two.
   function automatic logic shift_two(input logic [3:0] r);
      return !(r == 4'd0 || r == 4'd1 || r == 4'd8 || r == 4'd15);
   endfunction
   function automatic logic [1:28] rot(input logic [1:28] h, input logic left, input logic two);
      return left ? (two ? {h[3:28], h[1:2]} : {h[2:28], h[1]})
                  : (two ? {h[27:28], h[1:26]} : {h[28], h[1:27]});
   endfunction
   state_t      state, state_n;
   logic [1:28] c, d, c_n, d_n;
   logic [3:0]  round, round_n, step;
   logic [1:56] pk;
   logic        fwd, fwd_n, last, sh2, unused_parity;
`ifdef DES_KS_ENC_MODE_EN
   logic enc_q;
   always_ff @(posedge clk)
      if (rst) enc_q <= 1'b0;
      else if (bus.key_valid && state == IDLE) enc_q <= bus.enc;
   assign fwd   = enc_q;
   assign fwd_n = bus.enc;
`else
   assign fwd   = 1'b0;
   assign fwd_n = 1'b0;
`endif
   assign unused_parity = ^{bus.key_in[8], bus.key_in[16], bus.key_in[24], bus.key_in[32],
                            bus.key_in[40], bus.key_in[48], bus.key_in[56], bus.key_in[64]};
   assign pk   = pc1(bus.key_in);
   assign step = fwd ? round + 4'd1 : round - 4'd1;
   assign sh2  = shift_two(fwd ? step : round);
   assign last = fwd ? round == 4'd15 : round == 4'd0;
   always_comb begin
      state_n = state;
      c_n     = c;
      d_n     = d;
      round_n = round;
      if (bus.key_valid && state == IDLE) begin
         state_n = RUN;
         c_n     = fwd_n ? rot(pk[1:28], 1'b1, 1'b0) : pk[1:28];
         d_n     = fwd_n ? rot(pk[29:56], 1'b1, 1'b0) : pk[29:56];
         round_n = fwd_n ? 4'd0 : 4'd15;
      end else if (state == RUN && bus.subkey_ready) begin
         state_n = last ? IDLE : RUN;
         c_n     = last ? c : rot(c, fwd, sh2);
         d_n     = last ? d : rot(d, fwd, sh2);
         round_n = last ? round : step;
      end
   end
   always_ff @(posedge clk)
      if (rst) begin
         state <= IDLE;
         c     <= '0;
         d     <= '0;
         round <= 4'd15;
      end else begin
         state <= state_n;
         c     <= c_n;
         d     <= d_n;
         round <= round_n;
      end
   assign bus.key_ready    = state == IDLE;
   assign bus.subkey_valid = state == RUN;
   assign bus.busy         = state == RUN;
   assign bus.subkey       = pc2({c, d});
   assign bus.subkey_round = round;
endmodule

// File: tb/tb_des_key_sched_dec.sv
// tb_des_key_sched_dec: directed + randomized checks of des_key_sched_dec against a textbook DES key schedule.
// Define DES_KS_ENC_MODE_EN to also exercise encryption order.
module tb_des_key_sched_dec;
   localparam int PC1 [0:55] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
   localparam int PC2 [0:47] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
   localparam int SHIFTS [1:16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
   localparam logic [1:64] KEY_A = 64'h133457799BBCDFF1;
   localparam logic [1:64] KEY_P = 64'h123556789ABDDEF0;
   logic clk = 1'b0;
   logic rst;
   int checks = 0;
   int failures = 0;
   logic [1:48] ek [1:16];
   logic [1:48] got [0:15];
   logic [1:48] gota [0:15];
   des_key_sched_dec_if bus();
   des_key_sched_dec dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask
   // Classic forward schedule: rotate C/D left one bit at a time, record PC-2 of each round.
   task automatic model(input logic [1:64] key);
      logic [1:28] c, d;
      logic [1:56] cd;
      for (int i = 0; i < 28; i++) begin
         c[i+1] = key[PC1[i]];
         d[i+1] = key[PC1[i+28]];
      end
      for (int r = 1; r <= 16; r++) begin
         for (int s = 0; s < SHIFTS[r]; s++) begin
            c = {c[2:28], c[1]};
            d = {d[2:28], d[1]};
         end
         cd = {c, d};
         for (int j = 0; j < 48; j++) ek[r][j+1] = cd[PC2[j]];
      end
   endtask
   task automatic run_sched(input logic [1:64] key, input bit enc_m, input bit bp,
                            input int hold_r, input int cut_r, input bit spam);
      int idx;
      int held = 0;
      model(key);
      check("accept_key_ready", 64'(bus.key_ready), 64'd1);
      bus.key_in    = key;
      bus.key_valid = 1'b1;
`ifdef DES_KS_ENC_MODE_EN
      bus.enc = enc_m;
`endif
      @(posedge clk); #1;
      bus.key_valid = spam;
      if (spam) bus.key_in = 64'h0E329232EA6D0D73;
      for (int n = 0; n < 16; n++) begin
         idx = enc_m ? n + 1 : 16 - n;
         bus.key_valid = spam && n < 15;
         do begin
            check("run_valid", 64'(bus.subkey_valid), 64'd1);
            check("run_busy", 64'(bus.busy), 64'd1);
            check("run_key_ready", 64'(bus.key_ready), 64'd0);
            check("run_round", 64'(bus.subkey_round), 64'(idx - 1));
            check("run_subkey", 64'(bus.subkey), 64'(ek[idx]));
            got[n] = bus.subkey;
            if (cut_r == idx - 1) begin
               rst = 1'b1;
               bus.key_valid = 1'b0;
               @(posedge clk); #1;
               rst = 1'b0;
               check("cut_valid", 64'(bus.subkey_valid), 64'd0);
               check("cut_key_ready", 64'(bus.key_ready), 64'd1);
               check("cut_busy", 64'(bus.busy), 64'd0);
               check("cut_round", 64'(bus.subkey_round), 64'd15);
               check("cut_subkey", 64'(bus.subkey), 64'd0);
               return;
            end
            if (hold_r == idx - 1 && held < 5) begin
               bus.subkey_ready = 1'b0;
               held++;
            end else bus.subkey_ready = !bp || ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
         end while (!bus.subkey_ready);
      end
      check("end_valid", 64'(bus.subkey_valid), 64'd0);
      check("end_key_ready", 64'(bus.key_ready), 64'd1);
      check("end_busy", 64'(bus.busy), 64'd0);
      bus.subkey_ready = 1'b0;
      @(posedge clk); #1;
      check("idle_stays_idle", 64'(bus.subkey_valid), 64'd0);
   endtask
   initial begin
      rst = 1'b1;
      bus.key_in = '0;
      bus.key_valid = 1'b0;
      bus.subkey_ready = 1'b0;
`ifdef DES_KS_ENC_MODE_EN
      bus.enc = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      check("rst_key_ready", 64'(bus.key_ready), 64'd1);
      check("rst_valid", 64'(bus.subkey_valid), 64'd0);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_round", 64'(bus.subkey_round), 64'd15);
      check("rst_subkey", 64'(bus.subkey), 64'd0);
      rst = 1'b0;
      run_sched(KEY_A, 1'b0, 1'b0, -1, -1, 1'b0);
      check("vec_first_k16", 64'(got[0]), 64'h0000CB3D8B0E17F5);
      check("vec_last_k1", 64'(got[15]), 64'h00001B02EFFC7072);
      run_sched(KEY_A, 1'b0, 1'b1, 12, -1, 1'b0);
      run_sched(KEY_A, 1'b0, 1'b0, -1, -1, 1'b1);
      check("ignore_first_k16", 64'(got[0]), 64'h0000CB3D8B0E17F5);
      run_sched(KEY_A, 1'b0, 1'b0, -1, 8, 1'b0);
      run_sched({$urandom, $urandom}, 1'b0, 1'b1, -1, -1, 1'b0);
      run_sched(KEY_A, 1'b0, 1'b0, -1, -1, 1'b0);
      for (int n = 0; n < 16; n++) gota[n] = got[n];
      run_sched(KEY_P, 1'b0, 1'b1, -1, -1, 1'b0);
      for (int n = 0; n < 16; n++) check("parity_invariance", 64'(got[n]), 64'(gota[n]));
      for (int k = 0; k < 3; k++) run_sched({$urandom, $urandom}, 1'b0, 1'b1, $urandom_range(0, 15), -1, 1'b0);
`ifdef DES_KS_ENC_MODE_EN
      run_sched(KEY_A, 1'b1, 1'b0, -1, -1, 1'b0);
      check("enc_first_k1", 64'(got[0]), 64'h00001B02EFFC7072);
      check("enc_last_k16", 64'(got[15]), 64'h0000CB3D8B0E17F5);
      run_sched({$urandom, $urandom}, 1'b1, 1'b1, 3, -1, 1'b1);
      run_sched(KEY_A, 1'b0, 1'b1, -1, -1, 1'b0);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/des_key_sched_dec.md
Name: des_key_sched_dec

Overview:
- Sequential DES key scheduler that outputs the 16 round subkeys in decryption order (K16 first, K1 last), one subkey per accepted handshake.
- Sits beside the DES round datapath, which consumes 48-bit subkeys.
- Produces each subkey from a registered 56-bit C/D state by right-rotation, with no 16-entry key storage.
- Bit numbering follows FIPS 46-3: bit 1 is the MSB.

Parameters:
- None. Widths are fixed by the DES standard.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- key_in  input  [1:64]  DES key; parity bits 8,16,...,64 are ignored
- key_valid  input  1  key_in is valid
- key_ready  output  1  block can accept a new key
- subkey  output  [1:48]  current round subkey, PC-2 of the C/D state
- subkey_round  output  4  round index minus 1 (15 = K16 ... 0 = K1)
- subkey_valid  output  1  subkey and subkey_round are valid
- subkey_ready  input  1  consumer accepts the current subkey
- busy  output  1  a schedule is in progress

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, C=D=0, subkey_round=4'd15, key_ready=1, subkey_valid=0, busy=0. subkey=PC2(0)=48'h0.
- FSM states:
  - IDLE: key_ready=1, subkey_valid=0.
  - RUN: key_ready=0, subkey_valid=1, busy=1.
- Key accept:
  - Occurs on key_valid && key_ready at edge t.
  - At t: C||D <= PC1(key_in), which is 56 bits with C = bits 1..28 and D = bits 29..56. subkey_round <= 15. state <= RUN.
  - subkey_valid rises at t+1 with subkey=K16. Latency is 1 cycle.
  - K16 needs no rotation, because the total left shift over 16 rounds is 28 (C16=C0, D16=D0).
- Subkey advance:
  - Occurs on subkey_valid && subkey_ready at round index r (0..15).
  - If r>0: C and D each rotate right by SHIFT[r], then subkey_round <= r-1.
  - SHIFT[r] for r=0..15 is 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1. Per-half rotate: bit i moves to i+s mod 28.
  - If r==0: state <= IDLE, with key_ready=1 and subkey_valid=0 from the next cycle. C and D keep their value.
- Backpressure:
  - While subkey_valid && !subkey_ready, subkey, subkey_round and C/D are held stable.
  - No combinational path from subkey_ready to subkey_valid.
- subkey is combinational PC-2 of the registered C/D. Nothing is registered after PC-2.
- key_valid during RUN is ignored and the key is not captured. The source must hold key_valid until it sees key_ready.
- Back-to-back keys:
  - The earliest new accept is the cycle after the K1 handshake, since key_ready=1 only in IDLE.
  - Minimum schedule length is 17 cycles per key at subkey_ready=1: 1 accept + 16 subkeys.
- rst asserted mid-RUN: return to reset values on the next edge. The partial schedule is discarded and no further subkeys are output.
- rst has priority over any simultaneous handshake.

Optional Feature:
- Macro DES_KS_ENC_MODE_EN.
- Defined:
  - Adds input port enc (1 bit), sampled at key accept and held for the whole schedule.
  - enc=1 gives encryption order. On accept: C,D <= rotl(PC1, 1) and subkey_round <= 0, so the first subkey is K1.
  - On each advance at round r<15: rotate left by SHIFT[r+1], then round <= r+1.
  - The schedule ends after the round 15 handshake.
  - enc=0 behaves exactly as the base block.
- Undefined: no enc port; decryption order only.

Test Plan:
- Decrypt vector: rst 2 cycles, then key_in=64'h133457799BBCDFF1 with key_valid for 1 cycle and subkey_ready=1.
  - Next cycle: subkey=48'hCB3D8B0E17F5, subkey_round=15.
  - 15 cycles later: subkey=48'h1B02EFFC7072, subkey_round=0.
  - Then subkey_valid=0 and key_ready=1.
- Backpressure: same key, subkey_ready held low 5 cycles at round 12 → subkey and subkey_round stay constant; the total sequence matches the reference model.
- Busy-ignore: a second key_valid with key 64'h0E329232EA6D0D73 during RUN → ignored. Schedule continues for 64'h133457799BBCDFF1.
- Mid-run reset: rst at round 8 → next cycle subkey_valid=0, key_ready=1, busy=0. A new key then starts cleanly with K16 first.
- Parity invariance: key 64'h133457799BBCDFF1 vs the same key with all parity bits flipped (64'h123556789ABDDEF0) → identical subkey sequences.
- With DES_KS_ENC_MODE_EN and enc=1: same key → first subkey=48'h1B02EFFC7072 (round 0), last subkey=48'hCB3D8B0E17F5 (round 15).
